// File: rtl/pe_feeder.sv
// Transmit end of the multicast-to-PE link: loads a filter row once per job, then
// reloads and streams an imap row to a single PE for each row pass.
module pe_feeder #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int FILT_LEN = 3,
    parameter int IMAP_LEN = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] weight_base_addr,
    input  logic [ADDR_W-1:0] imap_base_addr,
    input  logic [ADDR_W-1:0] imap_stride,
    input  logic [5:0]        num_passes,
    input  logic [DATA_W-1:0] psum_init,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              to_mult_enable,
    output logic              to_mult_valid,
    output logic [DATA_W-1:0] to_mult_weight_value,
    output logic [DATA_W-1:0] to_mult_imap_value,
    output logic [DATA_W-1:0] to_mult_psum_value,
    input  logic              from_mult_ready,
    output logic              busy,
    output logic              done
);
    localparam int TOT_LEN = FILT_LEN + IMAP_LEN;
    localparam int IDX_W   = $clog2(TOT_LEN + 1);
    localparam int BEAT_W  = $clog2(IMAP_LEN + 1);
    localparam logic [IDX_W-1:0]  LAST_W_IDX = IDX_W'(TOT_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_I_IDX = IDX_W'(IMAP_LEN - 1);
    localparam logic [IDX_W-1:0]  FILT_IDX   = IDX_W'(FILT_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(IMAP_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, FETCH_LAST, ARM, STREAM, WAIT, DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] weight_base;
    logic [ADDR_W-1:0] imap_base;
    logic [ADDR_W-1:0] stride;
    logic [5:0]        passes;
    logic [5:0]        pass_cnt;
    logic [DATA_W-1:0] psum_lat;
    logic              fetch_w;
    logic [IDX_W-1:0]  fetch_idx;
    logic [BEAT_W-1:0] beat;

    logic [DATA_W-1:0] weight_q [FILT_LEN];
    logic [DATA_W-1:0] imap_q   [IMAP_LEN];

    logic              vld_p1;
    logic              cap_w_p1;
    logic [IDX_W-1:0]  cap_idx_p1;

    logic              in_w;
    logic              fetch_last;
    logic              more_passes;
    logic [IDX_W-1:0]  imap_idx;
    logic [ADDR_W-1:0] fetch_addr;

    // Weights occupy the first FILT_LEN fetch slots only on the first pass of a job
    always_comb begin
        in_w        = fetch_w && (fetch_idx < FILT_IDX);
        imap_idx    = fetch_w ? (fetch_idx - FILT_IDX) : fetch_idx;
        fetch_addr  = in_w ? (weight_base + ADDR_W'(fetch_idx))
                           : (imap_base + ADDR_W'(imap_idx));
        fetch_last  = (fetch_idx == (fetch_w ? LAST_W_IDX : LAST_I_IDX));
        more_passes = (({1'b0, pass_cnt} + 7'd1) < {1'b0, passes});
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start) state_nxt = (num_passes == 6'd0) ? DONE : FETCH;
            FETCH:      if (fetch_last) state_nxt = FETCH_LAST;
            FETCH_LAST: state_nxt = ARM;
            ARM:        state_nxt = STREAM;
            STREAM:     if (beat == LAST_BEAT) state_nxt = WAIT;
            WAIT:       if (from_mult_ready) state_nxt = more_passes ? FETCH : DONE;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en            = (state == FETCH);
        mem_rd_addr          = mem_rd_en ? fetch_addr : '0;
        to_mult_enable       = (state == ARM);
        to_mult_valid        = (state == STREAM);
        to_mult_weight_value = '0;
        to_mult_imap_value   = '0;
        to_mult_psum_value   = '0;
        if (to_mult_valid) begin
            for (int k = 0; k < IMAP_LEN; k++)
                if (beat == BEAT_W'(k)) to_mult_imap_value = imap_q[k];
            for (int k = 0; k < FILT_LEN; k++)
                if (beat == BEAT_W'(k)) to_mult_weight_value = weight_q[k];
            if (beat == '0) to_mult_psum_value = psum_lat;
        end
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            weight_base <= '0;
            imap_base   <= '0;
            stride      <= '0;
            passes      <= '0;
            pass_cnt    <= '0;
            psum_lat    <= '0;
            fetch_w     <= 1'b0;
            fetch_idx   <= '0;
            beat        <= '0;
            vld_p1      <= 1'b0;
            cap_w_p1    <= 1'b0;
            cap_idx_p1  <= '0;
        end else begin
            state      <= state_nxt;
            vld_p1     <= mem_rd_en;
            cap_w_p1   <= in_w;
            cap_idx_p1 <= in_w ? fetch_idx : imap_idx;
            case (state)
                IDLE: begin
                    if (start) begin
                        weight_base <= weight_base_addr;
                        imap_base   <= imap_base_addr;
                        stride      <= imap_stride;
                        passes      <= num_passes;
                        psum_lat    <= psum_init;
                        pass_cnt    <= '0;
                        fetch_w     <= 1'b1;
                        fetch_idx   <= '0;
                    end
                end
                FETCH:  fetch_idx <= fetch_last ? '0 : (fetch_idx + IDX_W'(1));
                ARM:    beat <= '0;
                STREAM: beat <= beat + BEAT_W'(1);
                WAIT: begin
                    if (from_mult_ready) begin
                        pass_cnt  <= pass_cnt + 6'd1;
                        imap_base <= imap_base + stride;
                        fetch_w   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture stage: read data returns one cycle after its strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FILT_LEN; k++) weight_q[k] <= '0;
            for (int k = 0; k < IMAP_LEN; k++) imap_q[k] <= '0;
        end else if (vld_p1) begin
            for (int k = 0; k < FILT_LEN; k++)
                if (cap_w_p1 && (cap_idx_p1 == IDX_W'(k))) weight_q[k] <= mem_rd_data;
            for (int k = 0; k < IMAP_LEN; k++)
                if (!cap_w_p1 && (cap_idx_p1 == IDX_W'(k))) imap_q[k] <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: a buffer model plus a job-level reference model of the
// expected read addresses and PE beats, checked every cycle by a monitor.
module tb_pe_feeder;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int FL = 3;
    localparam int IL = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] weight_base_addr = '0;
    logic [AW-1:0] imap_base_addr = '0;
    logic [AW-1:0] imap_stride = '0;
    logic [5:0]    num_passes = '0;
    logic [DW-1:0] psum_init = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          to_mult_enable;
    logic          to_mult_valid;
    logic [DW-1:0] to_mult_weight_value;
    logic [DW-1:0] to_mult_imap_value;
    logic [DW-1:0] to_mult_psum_value;
    logic          from_mult_ready = 1'b0;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    pe_feeder #(.DATA_W(DW), .ADDR_W(AW), .FILT_LEN(FL), .IMAP_LEN(IL)) dut (
        .clk(clk), .rst(rst), .start(start),
        .weight_base_addr(weight_base_addr), .imap_base_addr(imap_base_addr),
        .imap_stride(imap_stride), .num_passes(num_passes), .psum_init(psum_init),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .to_mult_enable(to_mult_enable), .to_mult_valid(to_mult_valid),
        .to_mult_weight_value(to_mult_weight_value), .to_mult_imap_value(to_mult_imap_value),
        .to_mult_psum_value(to_mult_psum_value), .from_mult_ready(from_mult_ready),
        .busy(busy), .done(done)
    );

    logic [DW-1:0] mem [256];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [DW-1:0] w;
        logic [DW-1:0] i;
        logic [DW-1:0] p;
    } beat_t;

    beat_t         exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [AW-1:0] rd_log[$];
    logic [DW-1:0] beat_w [IL];
    logic [DW-1:0] beat_i [IL];
    logic [DW-1:0] beat_p [IL];
    int            beat_idx = 0;
    int            en_count = 0;
    beat_t         mon_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) begin
                rd_log.push_back(mem_rd_addr);
                if (addr_q.size() == 0) fail("unexpected_read");
                else check("rd_addr", mem_rd_addr, addr_q.pop_front());
            end
            if (to_mult_enable) begin
                en_count++;
                beat_idx = 0;
            end
            if (to_mult_valid) begin
                if (exp_q.size() == 0) fail("unexpected_beat");
                else begin
                    mon_b = exp_q.pop_front();
                    check("beat_weight", to_mult_weight_value, mon_b.w);
                    check("beat_imap", to_mult_imap_value, mon_b.i);
                    check("beat_psum", to_mult_psum_value, mon_b.p);
                end
                if (beat_idx < IL) begin
                    beat_w[beat_idx] = to_mult_weight_value;
                    beat_i[beat_idx] = to_mult_imap_value;
                    beat_p[beat_idx] = to_mult_psum_value;
                end
                beat_idx++;
            end else begin
                check("idle_buses", to_mult_weight_value | to_mult_imap_value | to_mult_psum_value, 0);
            end
        end
    end

    // Job-level model: every read address and every beat a job must produce
    task automatic load_model(input logic [AW-1:0] wb, input logic [AW-1:0] ib,
                              input logic [AW-1:0] st, input logic [5:0] np,
                              input logic [DW-1:0] ps);
        beat_t         b;
        logic [AW-1:0] a;
        logic [AW-1:0] wa;
        addr_q.delete();
        exp_q.delete();
        rd_log.delete();
        for (int p = 0; p < int'(np); p++) begin
            if (p == 0)
                for (int k = 0; k < FL; k++) begin
                    wa = AW'(int'(wb) + k);
                    addr_q.push_back(wa);
                end
            for (int j = 0; j < IL; j++) begin
                a = AW'(int'(ib) + p * int'(st) + j);
                wa = AW'(int'(wb) + j);
                addr_q.push_back(a);
                b.w = (j < FL) ? mem[wa] : '0;
                b.i = mem[a];
                b.p = (j == 0) ? ps : '0;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic wait_for(input int which, input string name, output int c);
        bit hit;
        hit = 1'b0;
        c = cyc;
        for (int n = 0; n < 300 && !hit; n++) begin
            case (which)
                0: hit = to_mult_enable;
                1: hit = to_mult_valid;
                2: hit = !to_mult_valid;
                default: hit = done;
            endcase
            if (hit) c = cyc;
            else @(negedge clk);
        end
        if (!hit) fail({name, "_timeout"});
    endtask

    task automatic run_job(input logic [AW-1:0] wb, input logic [AW-1:0] ib,
                           input logic [AW-1:0] st, input logic [5:0] np,
                           input logic [DW-1:0] ps, input int gap,
                           input bit hold, input bit restart);
        int sc, c, rc, en0;
        load_model(wb, ib, st, np, ps);
        en0 = en_count;
        @(negedge clk);
        weight_base_addr = wb;
        imap_base_addr = ib;
        imap_stride = st;
        num_passes = np;
        psum_init = ps;
        from_mult_ready = hold;
        start = 1'b1;
        sc = cyc;
        @(negedge clk);
        start = 1'b0;
        if (restart) begin
            weight_base_addr = 8'd200;
            num_passes = 6'd9;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (np == 6'd0) begin
            wait_for(3, "done_np0", c);
            check("done_lat_np0", c - sc, 1);
            check("no_enable_np0", en_count - en0, 0);
        end else begin
            rc = sc;
            for (int p = 0; p < int'(np); p++) begin
                wait_for(0, "enable", c);
                if (p == 0) check("enable_lat_first", c - rc, 10);
                else check("enable_lat_pass", c - rc, 7);
                wait_for(1, "stream_start", c);
                wait_for(2, "stream_end", c);
                if (hold) rc = c;
                else begin
                    repeat (gap) @(negedge clk);
                    check("waiting_busy", {busy, done}, 2'b10);
                    from_mult_ready = 1'b1;
                    rc = cyc;
                    @(negedge clk);
                    from_mult_ready = 1'b0;
                end
            end
            wait_for(3, "done", c);
            check("done_lat", c - rc, 1);
            check("enable_count", en_count - en0, np);
        end
        check("reads_left", addr_q.size(), 0);
        check("beats_left", exp_q.size(), 0);
        from_mult_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        for (int i = 0; i < 256; i++) mem[i] = DW'(i + 1);

        #2 rst = 1'b1;
        #1;
        check("reset_ctrl", {busy, done, mem_rd_en, to_mult_enable, to_mult_valid}, 0);
        check("reset_buses", to_mult_weight_value | to_mult_imap_value | to_mult_psum_value
                             | DW'(mem_rd_addr), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single pass: weights 1,2,3 and imap 4..8
        run_job(8'd0, 8'd3, 8'd0, 6'd1, 32'd7, 4, 1'b0, 1'b0);
        check("p1_w0", beat_w[0], 1);
        check("p1_w2", beat_w[2], 3);
        check("p1_w3", beat_w[3], 0);
        check("p1_i0", beat_i[0], 4);
        check("p1_i4", beat_i[4], 8);
        check("p1_ps0", beat_p[0], 7);
        check("p1_ps1", beat_p[1], 0);

        // Three passes, stride 1: last pass must carry imap 6..10 with the same weights
        run_job(8'd0, 8'd3, 8'd1, 6'd3, 32'd9, 2, 1'b0, 1'b0);
        check("p3_last_i0", beat_i[0], 6);
        check("p3_last_i4", beat_i[4], 10);
        check("p3_last_w1", beat_w[1], 2);
        check("p3_reads", rd_log.size(), 18);

        run_job(8'd0, 8'd3, 8'd1, 6'd0, 32'd1, 0, 1'b0, 1'b0);
        check("np0_reads", rd_log.size(), 0);

        run_job(8'd10, 8'd40, 8'd5, 6'd2, 32'd3, 0, 1'b1, 1'b0);

        run_job(8'd4, 8'd50, 8'd0, 6'd1, 32'd11, 1, 1'b0, 1'b1);

        // Imap addresses wrap past the top of the buffer
        run_job(8'd0, 8'd254, 8'd0, 6'd1, 32'd0, 1, 1'b0, 1'b0);
        check("wrap_a3", rd_log[3], 254);
        check("wrap_a4", rd_log[4], 255);
        check("wrap_a5", rd_log[5], 0);
        check("wrap_a7", rd_log[7], 2);
        check("wrap_i1", beat_i[1], 256);
        check("wrap_i2", beat_i[2], 1);

        // Reset in the middle of a stream
        load_model(8'd0, 8'd10, 8'd0, 6'd2, 32'd5);
        @(negedge clk);
        weight_base_addr = 8'd0;
        imap_base_addr = 8'd10;
        imap_stride = 8'd0;
        num_passes = 6'd2;
        psum_init = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for(1, "rst_stream", c);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_ctrl", {busy, done, mem_rd_en, to_mult_enable, to_mult_valid}, 0);
        check("midrst_buses", to_mult_weight_value | to_mult_imap_value | to_mult_psum_value, 0);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("post_rst_idle", {busy, done}, 0);
        end
        run_job(8'd1, 8'd20, 8'd2, 6'd2, 32'd13, 3, 1'b0, 1'b0);
        check("fresh_w0", beat_w[0], 2);
        check("fresh_i0", beat_i[0], 23);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pe_feeder.md
Name: pe_feeder

Overview:
- Transmit end of the multicast-to-PE link; drives the enable, weight, imap and psum value buses that the convolution PE consumes, and honours the PE's ready return.
- Per job: loads FILT_LEN weights and IMAP_LEN imap words from the global buffer into local registers, then streams them to one PE.
- Repeats the imap-only reload and stream for num_passes row passes.
- Sits between the global buffer read port and a single PE.

Parameters:
DATA_W, 32, width of weight/imap/psum words
ADDR_W, 8, global buffer address width
FILT_LEN, 3, weights per filter row
IMAP_LEN, 5, imap words per row pass (IMAP_LEN >= FILT_LEN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  job request, sampled only in IDLE
weight_base_addr  in  ADDR_W  first weight address
imap_base_addr  in  ADDR_W  first imap address, pass 0
imap_stride  in  ADDR_W  imap base increment per pass
num_passes  in  6  row passes per job
psum_init  in  DATA_W  psum value sent on beat 0
mem_rd_en  out  1  buffer read strobe
mem_rd_addr  out  ADDR_W  buffer read address
mem_rd_data  in  DATA_W  read data, valid the cycle after mem_rd_en
to_mult_enable  out  1  one-cycle PE start pulse
to_mult_valid  out  1  data beat valid
to_mult_weight_value  out  DATA_W  weight beat
to_mult_imap_value  out  DATA_W  imap beat
to_mult_psum_value  out  DATA_W  psum beat
from_mult_ready  in  1  PE finished the pass
busy  out  1  high when not IDLE
done  out  1  one-cycle job-complete pulse

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; local weight/imap registers, pass and beat counters cleared. Reset mid-job aborts immediately; no pulse is emitted on release.
- States: IDLE, FETCH, FETCH_LAST, ARM, STREAM, WAIT, DONE.
- IDLE:
  - start=1 latches all job inputs.
  - If num_passes=0, go to DONE.
  - Otherwise go to FETCH with fetch_w=1.
  - start while busy is ignored.
- FETCH:
  - One read per cycle, mem_rd_en=1.
  - If fetch_w=1: FILT_LEN reads at weight_base+i, then IMAP_LEN reads at cur_imap_base+j.
  - If fetch_w=0: imap reads only.
  - Each word is captured on the cycle after its read.
  - After the last read, go to FETCH_LAST, which captures the final word with mem_rd_en=0.
  - Addresses wrap modulo 2^ADDR_W.
- ARM: to_mult_enable=1 for exactly one cycle, then STREAM.
- STREAM:
  - IMAP_LEN consecutive beats, to_mult_valid=1.
  - Beat k: imap_value=imap[k].
  - weight_value=weight[k] for k<FILT_LEN, else 0.
  - psum_value=psum_init on k=0, else 0.
  - Then go to WAIT.
- Outside STREAM, the value buses are 0 and to_mult_valid=0.
- WAIT:
  - Hold until from_mult_ready=1.
  - If ready is already high on entry, leave after one cycle.
  - On exit, pass_cnt+1.
  - If pass_cnt < num_passes: cur_imap_base += imap_stride, fetch_w=0, go to FETCH.
  - Otherwise go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- Latency:
  - First job pass: to_mult_enable rises FILT_LEN+IMAP_LEN+2 cycles after the start edge (10 with defaults).
  - Later passes: to_mult_enable rises IMAP_LEN+2 cycles after the ready edge.
- from_mult_ready is ignored outside WAIT.
- Weights are fetched once per job and reused across passes.
- All arithmetic is unsigned, with wrap-around.

Test Plan:
- Single pass, buffer[i]=i+1, weight_base=0, imap_base=3, num_passes=1, psum_init=7, ready pulsed 4 cycles after STREAM:
  - enable high at cycle 10 after start.
  - Beats weight=1,2,3,0,0; imap=4,5,6,7,8; psum=7,0,0,0,0.
  - done one cycle after WAIT exits.
- num_passes=3, imap_stride=1:
  - Imap streams 4..8, 5..9, 6..10.
  - Weights identical each pass.
  - Only 5 reads per later pass.
  - Enable 7 cycles after each ready edge.
- num_passes=0: done pulses the cycle after start; no mem_rd_en and no to_mult_enable.
- from_mult_ready held high throughout: WAIT lasts one cycle.
- Start re-asserted while busy: ignored, with no extra fetch.
- Address wrap: imap_base=254 → reads 254,255,0,1,2.
- rst asserted mid-STREAM:
  - All outputs 0 and state IDLE immediately.
  - A new start after release behaves as a fresh job.
